// File: rtl/ysyx_24110006_mem_responder.sv
// Fixed-latency word-organised SRAM responder with valid/ready request and response channels.
// One transaction in flight; the memory access happens on the edge that enters RESP.
module ysyx_24110006_mem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wmask,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      cnt_r;
    logic [31:0]     addr_r;
    logic            wen_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wmask_r;
    logic            resp_valid_r;
    logic [31:0]     rdata_r;
    logic            err_r;

    logic            accept_s;
    logic            access_s;
    logic [31:0]     acc_addr_s;
    logic            acc_wen_s;
    logic [31:0]     acc_wdata_s;
    logic [3:0]      acc_wmask_s;
    logic [31:0]     offset_s;
    logic            in_range_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic            mem_we_s;

    logic [31:0]     mem [DEPTH];

    assign o_req_ready  = (state_r == IDLE) && i_reset_n;
    assign accept_s     = o_req_ready && i_req_valid;
    assign o_resp_valid = resp_valid_r;
    assign o_resp_rdata = rdata_r;
    assign o_resp_err   = err_r;

    // With LATENCY=1 the access uses the live request; otherwise the latched copy.
    always_comb begin
        acc_addr_s  = addr_r;
        acc_wen_s   = wen_r;
        acc_wdata_s = wdata_r;
        acc_wmask_s = wmask_r;
        if (state_r == IDLE) begin
            acc_addr_s  = i_req_addr;
            acc_wen_s   = i_req_wen;
            acc_wdata_s = i_req_wdata;
            acc_wmask_s = i_req_wmask;
        end else begin
            acc_addr_s  = addr_r;
            acc_wen_s   = wen_r;
            acc_wdata_s = wdata_r;
            acc_wmask_s = wmask_r;
        end
    end

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    always_comb begin
        offset_s   = acc_addr_s - BASE_ADDR;
        in_range_s = ({1'b0, offset_s} < SPAN);
        idx_s      = offset_s[DEPTH_LOG2+1:2];
        mem_we_s   = access_s && i_reset_n && acc_wen_s && in_range_s;
    end

    // Next-state logic; access_s marks the edge that enters RESP.
    always_comb begin
        state_s  = state_r;
        access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req_valid) begin
                    if (LATENCY == 1) begin
                        state_s  = RESP;
                        access_s = 1'b1;
                    end else begin
                        state_s  = BUSY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s  = RESP;
                    access_s = 1'b1;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latency counter, request latch and registered response.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= 32'd0;
            wen_r        <= 1'b0;
            wdata_r      <= 32'd0;
            wmask_r      <= 4'd0;
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
            err_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cnt_r   <= CNT_INIT;
                addr_r  <= i_req_addr;
                wen_r   <= i_req_wen;
                wdata_r <= i_req_wdata;
                wmask_r <= i_req_wmask;
            end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (access_s) begin
                resp_valid_r <= 1'b1;
                err_r        <= !in_range_s;
                rdata_r      <= (!acc_wen_s && in_range_s) ? mem[idx_s] : 32'd0;
            end else if ((state_r == RESP) && i_resp_ready) begin
                resp_valid_r <= 1'b0;
                rdata_r      <= 32'd0;
                err_r        <= 1'b0;
            end
        end
    end

    // SRAM array: byte-lane writes, contents survive reset.
    always_ff @(posedge i_clock) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wmask_s[b]) begin
                    mem[idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24110006_mem_responder.sv
// Directed bench: instance a uses LATENCY=2, instance b uses LATENCY=1.
module tb_ysyx_24110006_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;

    logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, err_a;
    logic [31:0] rdata_a;
    logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, err_b;
    logic [31:0] rdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24110006_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) dut_a (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid_a), .o_req_ready(req_ready_a),
        .i_req_addr(addr), .i_req_wen(wen), .i_req_wdata(wdata), .i_req_wmask(wmask),
        .o_resp_valid(resp_valid_a), .i_resp_ready(resp_ready_a),
        .o_resp_rdata(rdata_a), .o_resp_err(err_a)
    );

    ysyx_24110006_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) dut_b (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid_b), .o_req_ready(req_ready_b),
        .i_req_addr(addr), .i_req_wen(wen), .i_req_wdata(wdata), .i_req_wmask(wmask),
        .o_resp_valid(resp_valid_b), .i_resp_ready(resp_ready_b),
        .o_resp_rdata(rdata_b), .o_resp_err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold > 0 keeps resp_ready low that many cycles in RESP.
    task automatic txn(input bit sel, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] m, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        addr = a; wen = w; wdata = d; wmask = m;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        n = 0;
        while (!(sel ? req_ready_b : req_ready_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? resp_valid_b : resp_valid_a) && lat < 20);
        rd = sel ? rdata_b : rdata_a;
        er = sel ? err_b : err_a;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(sel ? resp_valid_b : resp_valid_a), 32'd1);
            check_eq("hold_rdata", sel ? rdata_b : rdata_a, rd);
            check_eq("hold_err", 32'(sel ? err_b : err_a), 32'(er));
            check_eq("hold_req_ready", 32'(sel ? req_ready_b : req_ready_a), 32'd0);
        end
        if (sel) resp_ready_b = 1'b1; else resp_ready_a = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_a = 1'b0;
        resp_ready_b = 1'b0;
        check_eq("resp_cleared", 32'(sel ? resp_valid_b : resp_valid_a), 32'd0);
        check_eq("rdata_cleared", sel ? rdata_b : rdata_a, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst_n = 1'b0;
        addr = 32'd0; wen = 1'b0; wdata = 32'd0; wmask = 4'd0;
        req_valid_a = 1'b0; resp_ready_a = 1'b0;
        req_valid_b = 1'b0; resp_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready_a), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_req_ready", 32'(req_ready_a), 32'd1);
        check_eq("rel_resp_valid", 32'(resp_valid_a), 32'd0);
        check_eq("rel_rdata", rdata_a, 32'd0);

        // Reset held with a pending write must not touch memory.
        txn(1'b0, 32'h8000_0030, 1'b1, 32'h1111_1111, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        rst_n = 1'b0;
        addr = 32'h8000_0030; wen = 1'b1; wdata = 32'h2222_2222; wmask = 4'hF;
        req_valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_ready_low", 32'(req_ready_a), 32'd0);
            check_eq("rst_valid_low", 32'(resp_valid_a), 32'd0);
        end
        req_valid_a = 1'b0;
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready_after", 32'(req_ready_a), 32'd1);
        txn(1'b0, 32'h8000_0030, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("rst_no_write", rd, 32'h1111_1111);

        // Full-word write then read back.
        txn(1'b0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
        check_eq("wr_lat", 32'(lat), 32'd2);
        check_eq("wr_rdata", rd, 32'd0);
        check_eq("wr_err", 32'(er), 32'd0);
        txn(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("rd_lat", 32'(lat), 32'd2);
        check_eq("rd_data", rd, 32'hDEAD_BEEF);
        check_eq("rd_err", 32'(er), 32'd0);

        // Byte-lane write, then empty-mask write, then low address bits ignored.
        txn(1'b0, 32'h8000_0010, 1'b1, 32'h00AA_0000, 4'b0100, 0, rd, er, lat);
        txn(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("byte_wr", rd, 32'hDEAA_BEEF);
        txn(1'b0, 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat);
        check_eq("mask0_err", 32'(er), 32'd0);
        txn(1'b0, 32'h8000_0013, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("mask0_nochg", rd, 32'hDEAA_BEEF);

        // Range boundaries.
        txn(1'b0, 32'h8000_0000, 1'b1, 32'h1234_5678, 4'hF, 0, rd, er, lat);
        txn(1'b0, 32'h7FFF_FFFC, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("below_err", 32'(er), 32'd1);
        check_eq("below_rdata", rd, 32'd0);
        txn(1'b0, 32'h8000_4000, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("above_err", 32'(er), 32'd1);
        check_eq("above_rdata", rd, 32'd0);
        check_eq("above_lat", 32'(lat), 32'd2);
        txn(1'b0, 32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
        check_eq("above_wr_err", 32'(er), 32'd1);
        txn(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("word0_kept", rd, 32'h1234_5678);
        txn(1'b0, 32'h8000_3FFC, 1'b1, 32'hCAFE_0001, 4'hF, 0, rd, er, lat);
        txn(1'b0, 32'h8000_3FFC, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("last_word", rd, 32'hCAFE_0001);
        check_eq("last_err", 32'(er), 32'd0);

        // Backpressure: response held five cycles.
        txn(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 5, rd, er, lat);
        check_eq("bp_data", rd, 32'hDEAA_BEEF);

        // Reset while BUSY on a write drops the write.
        txn(1'b0, 32'h8000_0020, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        addr = 32'h8000_0020; wen = 1'b1; wdata = 32'h5A5A_5A5A; wmask = 4'hF;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("busy_rst_valid", 32'(resp_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h8000_0020, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("busy_rst_old", rd, 32'hA5A5_A5A5);

        // LATENCY=1 instance: write then back-to-back reads.
        txn(1'b1, 32'h8000_0040, 1'b1, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat);
        check_eq("l1_wr_lat", 32'(lat), 32'd1);
        txn(1'b1, 32'h8000_0040, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("l1_rd_lat", 32'(lat), 32'd1);
        check_eq("l1_rd_data", rd, 32'h0BAD_F00D);
        txn(1'b1, 32'h8000_0040, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("l1_rd2_lat", 32'(lat), 32'd1);
        check_eq("l1_rd2_data", rd, 32'h0BAD_F00D);
        txn(1'b1, 32'h8000_4000, 1'b0, 32'd0, 4'h0, 0, rd, er, lat);
        check_eq("l1_err", 32'(er), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
